// File: rtl/pifo_cpu_access_master.sv
// pifo_cpu_access_master: single-outstanding host initiator for the PIFO
// calendar CPU read/write port.
//
// Optional feature macro: PIFO_CPU_TIMEOUT_EN (WAIT-state timeout abort).
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   host_req_*           valid/ready request channel (write, addr, wdata)
//   host_resp_*          valid/ready response channel (data, error)
//   cpu_rd_*             read strobe/index out, result strobe/data in
//   cpu_wr_*             write strobe/index/data out, completion strobe in
//   busy                 high whenever the FSM is not idle
module pifo_cpu_access_master #(
    parameter int PIFO_CALENDAR_SIZE        = 1024,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
    parameter int PIFO_ROOT_WIDTH           = 32,
    parameter int TIMEOUT_WIDTH             = 16,
    parameter int TIMEOUT_CYCLES            = 1000
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 host_req_valid,
    output logic                                 host_req_ready,
    input  logic                                 host_req_write,
    input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] host_req_addr,
    input  logic [PIFO_ROOT_WIDTH-1:0]           host_req_wdata,
    output logic                                 host_resp_valid,
    input  logic                                 host_resp_ready,
    output logic [PIFO_ROOT_WIDTH-1:0]           host_resp_data,
    output logic                                 host_resp_error,
    output logic                                 cpu_rd_valid,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_rd_addr,
    input  logic                                 cpu_rd_result_valid,
    input  logic [PIFO_ROOT_WIDTH-1:0]           cpu_rd_result,
    output logic                                 cpu_wr_valid,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr,
    output logic [PIFO_ROOT_WIDTH-1:0]           cpu_wr_data,
    input  logic                                 cpu_wr_result_valid,
    output logic                                 busy
);

    localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
    localparam int DW = PIFO_ROOT_WIDTH;
    localparam logic [IW:0] SIZE_V = (IW+1)'(PIFO_CALENDAR_SIZE);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_cfg_err
        $error("TIMEOUT_CYCLES out of range for TIMEOUT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nx;

    logic          req_write;
    logic [IW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          out_of_range;
    logic          hit;
    logic          timeout;

    logic          rd_valid_d, wr_valid_d, resp_valid_d, resp_error_d;
    logic [DW-1:0] resp_data_d;

    assign host_req_ready = rstn && (state == IDLE);
    assign busy           = (state != IDLE);
    assign accept         = host_req_valid && host_req_ready;
    assign out_of_range   = ({1'b0, host_req_addr} >= SIZE_V);
    // Only the strobe matching the outstanding operation counts.
    assign hit = (state == WAIT) &&
                 (req_write ? cpu_wr_result_valid : cpu_rd_result_valid);
    assign cpu_rd_addr = addr_q;
    assign cpu_wr_addr = addr_q;
    assign cpu_wr_data = wdata_q;

`ifdef PIFO_CPU_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT && !hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A strobe on the terminal cycle takes priority over the abort.
    assign timeout = (state == WAIT) && !hit &&
                     (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            req_write       <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            cpu_rd_valid    <= 1'b0;
            cpu_wr_valid    <= 1'b0;
            host_resp_valid <= 1'b0;
            host_resp_data  <= '0;
            host_resp_error <= 1'b0;
        end else begin
            state           <= state_nx;
            cpu_rd_valid    <= rd_valid_d;
            cpu_wr_valid    <= wr_valid_d;
            host_resp_valid <= resp_valid_d;
            host_resp_data  <= resp_data_d;
            host_resp_error <= resp_error_d;
            if (accept) begin
                req_write <= host_req_write;
                addr_q    <= host_req_addr;
                wdata_q   <= host_req_wdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = out_of_range ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (hit || timeout) state_nx = RESP;
            RESP:  if (host_resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_valid_d   = accept && !out_of_range && !host_req_write;
        wr_valid_d   = accept && !out_of_range && host_req_write;
        resp_valid_d = (state_nx == RESP);
        resp_data_d  = host_resp_data;
        resp_error_d = host_resp_error;
        unique case (state)
            IDLE: begin
                resp_data_d  = '0;
                resp_error_d = accept && out_of_range;
            end
            WAIT: begin
                if (hit) begin
                    resp_data_d  = req_write ? '0 : cpu_rd_result;
                    resp_error_d = 1'b0;
                end else if (timeout) begin
                    resp_data_d  = '0;
                    resp_error_d = 1'b1;
                end
            end
            RESP: begin
                if (host_resp_ready) begin
                    resp_data_d  = '0;
                    resp_error_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pifo_cpu_access_master.sv
// tb_pifo_cpu_access_master: directed bench for pifo_cpu_access_master.
// Calendar strobes are driven by hand on the expected cycles.
module tb_pifo_cpu_access_master;

    localparam int IW = 11;
    localparam int DW = 32;

`ifdef PIFO_CPU_TIMEOUT_EN
    localparam int      TMO_LAST = 9;
    localparam logic    TMO_ERR  = 1'b1;
`else
    localparam int      TMO_LAST = 19;
    localparam logic    TMO_ERR  = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_req_write;
    logic [IW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata;
    logic          host_resp_valid;
    logic          host_resp_ready;
    logic [DW-1:0] host_resp_data;
    logic          host_resp_error;
    logic          cpu_rd_valid;
    logic [IW-1:0] cpu_rd_addr;
    logic          cpu_rd_result_valid;
    logic [DW-1:0] cpu_rd_result;
    logic          cpu_wr_valid;
    logic [IW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_result_valid;
    logic          busy;

    int passed = 0;
    int total  = 0;

    pifo_cpu_access_master #(
        .PIFO_CALENDAR_SIZE        (1024),
        .PIFO_CALENDAR_INDEX_WIDTH (IW),
        .PIFO_ROOT_WIDTH           (DW),
        .TIMEOUT_WIDTH             (16),
        .TIMEOUT_CYCLES            (8)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .host_req_valid      (host_req_valid),
        .host_req_ready      (host_req_ready),
        .host_req_write      (host_req_write),
        .host_req_addr       (host_req_addr),
        .host_req_wdata      (host_req_wdata),
        .host_resp_valid     (host_resp_valid),
        .host_resp_ready     (host_resp_ready),
        .host_resp_data      (host_resp_data),
        .host_resp_error     (host_resp_error),
        .cpu_rd_valid        (cpu_rd_valid),
        .cpu_rd_addr         (cpu_rd_addr),
        .cpu_rd_result_valid (cpu_rd_result_valid),
        .cpu_rd_result       (cpu_rd_result),
        .cpu_wr_valid        (cpu_wr_valid),
        .cpu_wr_addr         (cpu_wr_addr),
        .cpu_wr_data         (cpu_wr_data),
        .cpu_wr_result_valid (cpu_wr_result_valid),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [IW-1:0] a,
                        input logic [DW-1:0] d);
        check("req_ready_idle", 32'(host_req_ready), 32'd1);
        host_req_valid = 1'b1;
        host_req_write = w;
        host_req_addr  = a;
        host_req_wdata = d;
        step();
        host_req_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {20'd0, 1'(host_req_ready), 1'(host_resp_valid),
               1'(host_resp_error), 1'(cpu_rd_valid), 1'(cpu_wr_valid),
               1'(busy), 6'd0},
              32'd0);
        check({tag, "_data"}, host_resp_data, 32'd0);
        check({tag, "_wdata"}, cpu_wr_data, 32'd0);
        check({tag, "_addr"}, 32'({cpu_rd_addr, cpu_wr_addr}), 32'd0);
    endtask

    task automatic finish_resp(input logic [DW-1:0] d, input logic e);
        check("resp_valid", 32'(host_resp_valid), 32'd1);
        check("resp_data", host_resp_data, d);
        check("resp_error", 32'(host_resp_error), 32'(e));
        host_resp_ready = 1'b1;
        step();
        host_resp_ready = 1'b0;
        check("resp_drop", 32'(host_resp_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        host_req_valid = 1'b0;
        host_req_write = 1'b0;
        host_req_addr = '0;
        host_req_wdata = '0;
        host_resp_ready = 1'b0;
        cpu_rd_result_valid = 1'b0;
        cpu_rd_result = '0;
        cpu_wr_result_valid = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rstn = 1'b1;
        step();
        check("req_ready_after_rst", 32'(host_req_ready), 32'd1);

        // read addr 5: strobe T+1, result T+2, response T+3
        send(1'b0, 11'd5, 32'h0);
        check("rd_strobe", 32'(cpu_rd_valid), 32'd1);
        check("rd_addr", 32'(cpu_rd_addr), 32'd5);
        check("rd_no_wr", 32'(cpu_wr_valid), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_req_ready", 32'(host_req_ready), 32'd0);
        step();
        check("rd_pulse_once", 32'(cpu_rd_valid), 32'd0);
        check("rd_no_resp_yet", 32'(host_resp_valid), 32'd0);
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result = 32'h8000_1234;
        step();
        cpu_rd_result_valid = 1'b0;
        cpu_rd_result = 32'h0;
        finish_resp(32'h8000_1234, 1'b0);

        // write addr 1023, completion 6 cycles after strobe
        send(1'b1, 11'd1023, 32'hA5A5_0001);
        check("wr_strobe", 32'(cpu_wr_valid), 32'd1);
        check("wr_addr", 32'(cpu_wr_addr), 32'd1023);
        check("wr_data", cpu_wr_data, 32'hA5A5_0001);
        check("wr_no_rd", 32'(cpu_rd_valid), 32'd0);
        for (int i = 2; i <= 6; i++) begin
            step();
            cpu_rd_result_valid = (i == 3);
            cpu_rd_result = 32'hBAD0_BAD0;
            check("wr_wait_busy", 32'(busy), 32'd1);
            check("wr_pulse_once", 32'(cpu_wr_valid), 32'd0);
            check("wr_wait_noresp", 32'(host_resp_valid), 32'd0);
            check("wr_addr_hold", 32'(cpu_wr_addr), 32'd1023);
        end
        step();
        cpu_rd_result_valid = 1'b0;
        cpu_wr_result_valid = 1'b1;
        check("wr_busy_t7", 32'(busy), 32'd1);
        step();
        cpu_wr_result_valid = 1'b0;
        check("wr_busy_resp", 32'(busy), 32'd1);
        finish_resp(32'h0, 1'b0);

        // out-of-range read, response held under backpressure
        send(1'b0, 11'd1024, 32'h0);
        check("oor_no_strobe", 32'(cpu_rd_valid), 32'd0);
        host_req_valid = 1'b1;
        host_req_write = 1'b0;
        host_req_addr = 11'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(host_resp_valid), 32'd1);
            check("bp_error", 32'(host_resp_error), 32'd1);
            check("bp_data", host_resp_data, 32'd0);
            check("bp_req_ready", 32'(host_req_ready), 32'd0);
            step();
        end
        host_resp_ready = 1'b1;
        step();
        host_resp_ready = 1'b0;
        check("b2b_ready", 32'(host_req_ready), 32'd1);
        step();
        host_req_valid = 1'b0;
        check("b2b_strobe", 32'(cpu_rd_valid), 32'd1);
        check("b2b_addr", 32'(cpu_rd_addr), 32'd7);
        step();
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result = 32'h0000_0011;
        step();
        cpu_rd_result_valid = 1'b0;
        finish_resp(32'h0000_0011, 1'b0);

        // write with no completion strobe
        send(1'b1, 11'd3, 32'h1234_5678);
        for (int i = 2; i <= TMO_LAST; i++) begin
            step();
            check("tmo_wait", 32'(host_resp_valid), 32'd0);
        end
        cpu_wr_result_valid = !TMO_ERR;
        step();
        cpu_wr_result_valid = 1'b0;
        finish_resp(32'h0, TMO_ERR);
        cpu_wr_result_valid = 1'b1;
        step();
        cpu_wr_result_valid = 1'b0;
        check("late_busy", 32'(busy), 32'd0);
        step();
        check("late_noresp", 32'(host_resp_valid), 32'd0);

        send(1'b0, 11'd9, 32'h0);
        step();
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result = 32'hDEAD_BEEF;
        step();
        cpu_rd_result_valid = 1'b0;
        finish_resp(32'hDEAD_BEEF, 1'b0);

        // strobe on the terminal timeout cycle is a success
        send(1'b1, 11'd4, 32'h0000_0044);
        for (int i = 2; i <= 9; i++) begin
            step();
            cpu_wr_result_valid = (i == 9);
        end
        step();
        cpu_wr_result_valid = 1'b0;
        finish_resp(32'h0, 1'b0);

        // reset in WAIT, stray result afterwards
        send(1'b0, 11'd2, 32'h0);
        step();
        check("rst_in_wait_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        step();
        check_all_zero("mid_reset");
        rstn = 1'b1;
        cpu_rd_result_valid = 1'b1;
        cpu_rd_result = 32'h5555_AAAA;
        step();
        cpu_rd_result_valid = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_noresp", 32'(host_resp_valid), 32'd0);
        step();
        check("stray_noresp2", 32'(host_resp_valid), 32'd0);
        check("stray_ready", 32'(host_req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
